l2_line_adaptor: RTL and testbench
==================================

Name: l2_line_adaptor

Overview:
- Responder for the L2 cache's physical-memory line interface. The L2 initiates whole-line reads and writebacks using a 32-bit address and 256-bit data.
- The block serves each request by driving a narrower burst interface to main memory, as a fixed-length beat sequence.
- It sits between the L2 cache and main memory. It owns all beat sequencing, line assembly and disassembly, and address alignment.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory data beat width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per line. This value is derived and must not be overridden.
- OFFSET_BITS, 5, byte-offset bits forced to zero on the burst address.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_read  in  1  L2 requests a line fill.
- line_write  in  1  L2 requests a line writeback.
- line_address  in  32  line address from the L2; low OFFSET_BITS are ignored.
- line_wdata  in  LINE_WIDTH  writeback line data.
- line_rdata  out  LINE_WIDTH  assembled fill line.
- line_resp  out  1  one-cycle completion strobe.
- burst_address  out  32  aligned address, held constant for the whole burst.
- burst_read  out  1  memory read burst in progress.
- burst_write  out  1  memory write burst in progress.
- burst_wdata  out  BEAT_WIDTH  current write beat.
- burst_rdata  in  BEAT_WIDTH  current read beat.
- burst_resp  in  1  memory accepted (write) or delivered (read) one beat this cycle.

Behaviour:
- Reset:
  - Synchronous reset returns the FSM to IDLE and the beat counter to 0.
  - All outputs, line_rdata and the internal buffer clear to 0 on the edge where rst=1, including in the middle of a burst.
  - burst_read and burst_write are low from the cycle after that edge.
  - No line_resp is ever issued for an aborted request.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - When line_read=1, latch the aligned address {line_address[31:5],5'b0} and go to RD_BURST.
  - When line_write=1 (and line_read=0), latch the aligned address and line_wdata into the buffer and go to WR_BURST.
  - If both requests are high, read wins and the write is ignored. A write is only started if line_write is still high in a later IDLE cycle.
  - burst_resp is ignored in IDLE and DONE.
- RD_BURST:
  - burst_read=1 and burst_address holds the latched address.
  - On each cycle with burst_resp=1, store burst_rdata into buffer bits [64k+63:64k], where k is the beat counter, then increment k.
  - Cycles with burst_resp=0 are stalls; state and counter hold.
  - After beat BEATS-1 is accepted, reset k to 0 and go to DONE. burst_read falls on that same edge.
- WR_BURST:
  - burst_write=1 and burst_wdata = buffer[64k+63:64k], driven combinationally from k.
  - k advances on burst_resp=1.
  - After the last beat, go to DONE.
- DONE:
  - line_resp=1 for exactly this one cycle, then go to IDLE.
  - After a read, line_rdata equals the assembled line from this cycle onward. It holds until the next read completes or reset; writes do not disturb it.
  - Line requests seen in DONE are not sampled.
- Latency:
  - A request sampled in IDLE at cycle 0 raises burst_* at cycle 1.
  - With burst_resp high every cycle, beats are accepted at cycles 1–4 and line_resp occurs at cycle 5.
  - Total latency is 1 + (beat cycles including stalls) + 1.
- After line_resp, the L2 must drop its request. If a request is still high in the following IDLE cycle, a new transaction starts.
- burst_read and burst_write are never high together.
- The beat counter is clog2(BEATS) bits wide. It wraps only through the explicit reset to 0 in the transition to DONE.

Decomposition:
- Package l2_adaptor_pkg holds:
  - typedef enum adaptor_state_t {IDLE, RD_BURST, WR_BURST, DONE};
  - localparams LINE_WIDTH, BEAT_WIDTH, BEATS, OFFSET_BITS;
  - typedef beat_idx_t [clog2(BEATS)-1:0].
- Sub-module line_beat_buffer:
  - A LINE_WIDTH register with three operations: whole-line load (writeback latch), single-beat write at an index (fill), and combinational beat read at an index.
  - It has a synchronous clear on rst.
- The top module holds the FSM, counter, address register and output muxing.

Test Plan:
- Read, no stalls: line_read at address 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with burst_resp held high.
  - burst_address=0x0000_1220 on cycles 1–4.
  - line_resp only at cycle 5.
  - line_rdata = {44..44,33..33,22..22,11..11}.
- Write with stalls: line_write with line_wdata = {D,C,B,A} (64-bit beats), burst_resp pattern 1,0,0,1,1,0,1.
  - burst_wdata shows A,B,B,B,C,D,D, matching k on each cycle.
  - line_resp occurs one cycle after the 4th accept.
  - burst_read stays 0 throughout.
- Eviction sequence: writeback to 0x0000_2FE0, then fill from 0x0000_3FE0 immediately after line_resp.
  - The write burst completes first.
  - The read starts the cycle after DONE.
  - line_rdata from the earlier read is unchanged during the write.
- Simultaneous requests: line_read and line_write both high in IDLE.
  - A read burst runs and burst_write=0.
  - With line_write held after line_resp, the write burst starts next.
- Reset mid-burst: rst=1 after 2 read beats.
  - On the next cycle burst_read=0, line_rdata=0 and no line_resp.
  - A new read afterwards assembles all 4 beats correctly from k=0.
- Idle noise: burst_resp toggling in IDLE with no request.
  - No state change, no line_resp, line_rdata unchanged.

Source files
------------

// File: rtl/l2_adaptor_pkg.sv
// Shared sizing, beat index type and FSM state type for the L2 line adaptor.
package l2_adaptor_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_IDX_W  = $clog2(BEATS);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide staging register: whole-line load for writebacks, per-beat
// write for fills, and a combinational beat read.
module line_beat_buffer
    import l2_adaptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic                  beat_we,
    input  beat_idx_t             beat_widx,
    input  logic [BEAT_WIDTH-1:0] beat_wdata,
    input  beat_idx_t             beat_ridx,
    output logic [BEAT_WIDTH-1:0] beat_rdata,
    output logic [LINE_WIDTH-1:0] line_o
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_line;
        end else if (beat_we) begin
            line_d[int'(beat_widx)*BEAT_WIDTH +: BEAT_WIDTH] = beat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_rdata = line_q[int'(beat_ridx)*BEAT_WIDTH +: BEAT_WIDTH];
    assign line_o     = line_q;

endmodule

// File: rtl/l2_line_adaptor.sv
// Serves L2 whole-line reads/writebacks as fixed-length beat bursts to memory.
//   state    | meaning
//   IDLE     | waiting for line_read / line_write (read wins)
//   RD_BURST | collecting BEATS read beats into the buffer
//   WR_BURST | sending BEATS buffered beats to memory
//   DONE     | one-cycle line_resp, then back to IDLE
module l2_line_adaptor
    import l2_adaptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
    localparam beat_idx_t   LAST_BEAT = beat_idx_t'(BEATS - 1);

    adaptor_state_t        state_q, state_d;
    beat_idx_t             k_q, k_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    logic                  buf_load;
    logic                  buf_we;
    logic [BEAT_WIDTH-1:0] buf_rbeat;
    logic [LINE_WIDTH-1:0] buf_line;
    logic [LINE_WIDTH-1:0] fill_line;

    line_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (buf_load),
        .load_line  (line_wdata),
        .beat_we    (buf_we),
        .beat_widx  (k_q),
        .beat_wdata (burst_rdata),
        .beat_ridx  (k_q),
        .beat_rdata (buf_rbeat),
        .line_o     (buf_line)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        buf_load = 1'b0;
        buf_we   = 1'b0;

        // Line as it will look once the current read beat lands, so the
        // completed fill is visible in the same cycle as line_resp.
        fill_line = buf_line;
        fill_line[int'(k_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;

        case (state_q)
            IDLE: begin
                if (line_read) begin
                    addr_d  = line_address & ADDR_MASK;
                    k_d     = '0;
                    state_d = RD_BURST;
                end else if (line_write) begin
                    addr_d   = line_address & ADDR_MASK;
                    k_d      = '0;
                    buf_load = 1'b1;
                    state_d  = WR_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    buf_we = 1'b1;
                    if (k_q == LAST_BEAT) begin
                        k_d     = '0;
                        rdata_d = fill_line;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + beat_idx_t'(1);
                    end
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    if (k_q == LAST_BEAT) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + beat_idx_t'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign burst_wdata   = (state_q == WR_BURST) ? buf_rbeat : '0;
    assign burst_address = addr_q;
    assign line_resp     = (state_q == DONE);
    assign line_rdata    = rdata_q;

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Scoreboard bench for l2_line_adaptor: stimulus pushes expected transactions,
// a negedge monitor checks bursts, beats, completion timing and line_rdata.
module tb_l2_line_adaptor;
    import l2_adaptor_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  line_read = 1'b0;
    logic                  line_write = 1'b0;
    logic [31:0]           line_address = '0;
    logic [LINE_WIDTH-1:0] line_wdata = '0;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_resp;
    logic [31:0]           burst_address;
    logic                  burst_read;
    logic                  burst_write;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata = '0;
    logic                  burst_resp = 1'b0;

    l2_line_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [255:0] line;
        int          resp_cyc;
    } exp_t;

    exp_t         txq[$];
    bit           pat_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           beat_cnt = 0;
    logic [255:0] model_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    // Accept pattern with exactly BEATS ones, the last entry always an accept.
    task automatic gen_pat(input int stall_pct);
        int n;
        bit b;
        n = 0;
        pat_q.delete();
        while (n < BEATS) begin
            b = ($urandom_range(99) >= stall_pct);
            pat_q.push_back(b);
            n += int'(b);
        end
    endtask

    // Plays pat_q on burst_resp starting right after the request edge, then
    // the DONE cycle (with burst_resp noise) and returns in IDLE.
    task automatic drive_beats(input logic [255:0] line, input bit rd);
        int idx;
        idx = 0;
        foreach (pat_q[i]) begin
            burst_resp  = pat_q[i];
            burst_rdata = (rd && pat_q[i]) ? line[idx*64 +: 64] : rand_beat();
            if (pat_q[i]) idx++;
            @(posedge clk); #1;
        end
        burst_resp  = 1'($urandom);
        burst_rdata = rand_beat();
        @(posedge clk); #1;
        burst_resp = 1'b0;
    endtask

    task automatic push_txn(input bit rd, input logic [31:0] addr, input logic [255:0] line);
        exp_t t;
        t.is_rd    = rd;
        t.addr     = addr & 32'hFFFF_FFE0;
        t.line     = line;
        t.resp_cyc = cyc + pat_q.size();
        txq.push_back(t);
    endtask

    // For reads, line is the memory contents returned beat by beat; for
    // writes, it is the writeback data.
    task automatic txn(input bit rd, input logic [31:0] addr, input logic [255:0] line);
        line_read    = rd;
        line_write   = !rd;
        line_address = addr;
        line_wdata   = rd ? rand_line() : line;
        @(posedge clk); #1;
        line_read  = 1'b0;
        line_write = 1'b0;
        push_txn(rd, addr, line);
        drive_beats(line, rd);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        burst_resp  = 1'b0;
        line_read   = 1'b0;
        line_write  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        txq.delete();
        beat_cnt    = 0;
        model_rdata = '0;
        chk("rst_burst_read", burst_read, 0);
        chk("rst_burst_write", burst_write, 0);
        chk("rst_line_resp", line_resp, 0);
        chk("rst_burst_addr", burst_address, 0);
        chk("rst_burst_wdata", burst_wdata, 0);
        chk("rst_line_rdata", line_rdata, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t t;
        if (!rst) begin
            chk("burst_exclusive", burst_read & burst_write, 0);
            if (burst_read || burst_write) begin
                if (txq.size() == 0) begin
                    chk("burst_unexpected", {burst_read, burst_write}, 0);
                end else begin
                    t = txq[0];
                    chk("burst_kind", {burst_read, burst_write}, t.is_rd ? 2'b10 : 2'b01);
                    chk("burst_addr", burst_address, t.addr);
                    if (beat_cnt >= BEATS)
                        chk("extra_beat", beat_cnt, BEATS - 1);
                    else if (burst_write)
                        chk("burst_wdata", burst_wdata, t.line[beat_cnt*64 +: 64]);
                    if (burst_resp) beat_cnt++;
                end
            end
            if (line_resp) begin
                if (txq.size() == 0) begin
                    chk("resp_unexpected", line_resp, 0);
                end else begin
                    t = txq.pop_front();
                    chk("resp_cycle", cyc, t.resp_cyc);
                    chk("resp_beats", beat_cnt, BEATS);
                    if (t.is_rd) model_rdata = t.line;
                end
                beat_cnt = 0;
            end
            chk("line_rdata", line_rdata, model_rdata);
        end
    end

    initial begin
        logic [255:0] ln;
        logic [255:0] wl;
        logic [63:0]  b0;
        logic [63:0]  b1;

        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Fill, no stalls.
        pat_q = '{1, 1, 1, 1};
        txn(1'b1, 32'h0000_1234, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});

        // Writeback with stalls: wdata sequence A,B,B,B,C,D,D.
        pat_q = '{1, 0, 0, 1, 1, 0, 1};
        txn(1'b0, 32'h0000_0040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

        // Eviction: writeback then immediate fill.
        gen_pat(30);
        txn(1'b0, 32'h0000_2FE0, rand_line());
        gen_pat(30);
        txn(1'b1, 32'h0000_3FE0, rand_line());

        // Simultaneous requests: read first, held write follows.
        ln = rand_line();
        wl = rand_line();
        line_read    = 1'b1;
        line_write   = 1'b1;
        line_address = 32'h0000_5A5F;
        line_wdata   = wl;
        gen_pat(25);
        @(posedge clk); #1;
        line_read = 1'b0;
        push_txn(1'b1, 32'h0000_5A5F, ln);
        drive_beats(ln, 1'b1);
        gen_pat(25);
        @(posedge clk); #1;
        line_write = 1'b0;
        push_txn(1'b0, 32'h0000_5A5F, wl);
        drive_beats(wl, 1'b0);

        // Reset after two read beats.
        b0 = rand_beat();
        b1 = rand_beat();
        line_read    = 1'b1;
        line_address = 32'h0000_7700;
        @(posedge clk); #1;
        line_read = 1'b0;
        pat_q = '{1, 1, 1, 1};
        push_txn(1'b1, 32'h0000_7700, rand_line());
        burst_resp  = 1'b1;
        burst_rdata = b0;
        @(posedge clk); #1;
        burst_rdata = b1;
        @(posedge clk); #1;
        do_reset();
        gen_pat(30);
        txn(1'b1, 32'h0000_7700, rand_line());

        // Idle noise on the memory side.
        ln = model_rdata;
        repeat (12) begin
            burst_resp  = 1'($urandom);
            burst_rdata = rand_beat();
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        chk("idle_rdata_hold", line_rdata, ln);

        // Random traffic.
        repeat (40) begin
            gen_pat($urandom_range(60));
            txn(1'($urandom), $urandom, rand_line());
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("txq_drained", txq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
